// File: rtl/md_issue_ctrl_if.sv
// Handshake bundle between the E-stage issue controller (master) and the
// multiply/divide unit plus pipeline control consumers (slave).
interface md_issue_ctrl_if;
  logic       e_valid;
  logic [3:0] e_op;
  logic       d_is_md;
  logic       busy;
  logic       start;
  logic [3:0] XALUOp;
  logic       HLWr;
  logic       stall;
  logic       proto_err;
  logic [1:0] state_o;

  modport master (
    input  e_valid, e_op, d_is_md, busy,
    output start, XALUOp, HLWr, stall, proto_err, state_o
  );

  modport slave (
    output e_valid, e_op, d_is_md, busy,
    input  start, XALUOp, HLWr, stall, proto_err, state_o
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: decodes the md
// instruction class, issues operations, stalls D while the unit is occupied,
// and watches the unit's busy handshake against the expected latency.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int SLACK    = 2
) (
  input  logic           clk,
  input  logic           reset,
  md_issue_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    BUSY  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  // Watchdog budgets: nominal latency plus tolerated overrun.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_LAT + SLACK);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_LAT + SLACK);

  state_t     state;
  logic [4:0] cnt;

  logic is_md;       // valid E-stage instruction of any md class
  logic is_muldiv;   // mult/multu/div/divu
  logic is_mt;       // mthi/mtlo
  logic issue_now;   // mult/div leaving IDLE this cycle

  // Decode the E-stage opcode class.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_md     = bus.e_valid && (bus.e_op[3] == 1'b0);
    is_muldiv = is_md && (bus.e_op[2] == 1'b0);
    is_mt     = is_md && (bus.e_op[2:1] == 2'b11);
    issue_now = (state == IDLE) && is_muldiv;
  end

  // Drive unit controls and the D-stage stall; only IDLE may issue or write HI/LO.
  always_comb begin
    bus.start   = 1'b0;
    bus.HLWr    = 1'b0;
    if (state == IDLE) begin
      bus.start = is_muldiv;
      bus.HLWr  = is_muldiv || is_mt;
    end
    bus.stall   = bus.d_is_md && ((state != IDLE) || issue_now);
    bus.XALUOp  = bus.e_valid ? bus.e_op : 4'b1111;
    bus.state_o = state;
  end

  // Sequence issue/execute/drain, track the latency watchdog and latch protocol errors.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      // An md instruction must never reach E while the unit is occupied.
      if (is_md && (state != IDLE))
        bus.proto_err <= 1'b1;

      case (state)
        IDLE: begin
          if (is_muldiv) begin
            cnt   <= bus.e_op[1] ? DIV_LOAD : MULT_LOAD;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The unit loads at the issue edge, so busy must already be high.
          if (!bus.busy) begin
            bus.proto_err <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt   <= cnt - 5'd1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.busy)
            state <= DRAIN;
          else if (cnt == 5'd0)
            bus.proto_err <= 1'b1;   // overran the latency budget; hold at 0
          else
            cnt <= cnt - 5'd1;
        end
        DRAIN: begin
          // HI/LO settled on busy's falling edge; reads are legal next cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed testbench for md_issue_ctrl: each task drives one scenario and
// compares outputs against hand-computed expectations.
module tb_md_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  md_issue_ctrl_if bus();

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .SLACK(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.e_valid = 1'b0;
    bus.e_op    = 4'hf;
    bus.d_is_md = 1'b0;
    bus.busy    = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.d_is_md = 1'b1;
    #3;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL rst_state: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0h want 0", bus.stall); end
    n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %0h want 0", bus.start); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0h want 0", bus.proto_err); end
    n_cmp++; if (bus.XALUOp !== 4'b1111) begin n_bad++; $display("FAIL rst_xaluop: got %0h want f", bus.XALUOp); end
    #4 reset = 1'b0;
    bus.d_is_md = 1'b0;
    step();
  endtask

  task automatic test_mult();
    logic [1:0] exp_st;
    bus.d_is_md = 1'b1;
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0000;
    #1;
    n_cmp++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL mult_start: got %0h want 1", bus.start); end
    n_cmp++; if (bus.HLWr !== 1'b1) begin n_bad++; $display("FAIL mult_hlwr: got %0h want 1", bus.HLWr); end
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL mult_stall_issue: got %0h want 1", bus.stall); end
    n_cmp++; if (bus.XALUOp !== 4'b0000) begin n_bad++; $display("FAIL mult_xaluop: got %0h want 0", bus.XALUOp); end
    step();
    bus.e_valid = 1'b0;
    bus.e_op    = 4'hf;
    for (int i = 0; i < 7; i++) begin
      bus.busy = (i < 5);
      #1;
      exp_st = (i == 0) ? 2'b01 : (i == 6) ? 2'b11 : 2'b10;
      n_cmp++; if (bus.state_o !== exp_st) begin n_bad++; $display("FAIL mult_state[%0d]: got %0h want %0h", i, bus.state_o, exp_st); end
      n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL mult_stall[%0d]: got %0h want 1", i, bus.stall); end
      n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL mult_nostart[%0d]: got %0h want 0", i, bus.start); end
      n_cmp++; if (bus.HLWr !== 1'b0) begin n_bad++; $display("FAIL mult_nohlwr[%0d]: got %0h want 0", i, bus.HLWr); end
      step();
    end
    bus.busy = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL mult_end_state: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mult_end_stall: got %0h want 0", bus.stall); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL mult_err: got %0h want 0", bus.proto_err); end
    idle_inputs();
  endtask

  task automatic test_divu();
    logic [1:0] exp_st;
    bus.d_is_md = 1'b0;
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0011;
    #1;
    n_cmp++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL divu_start: got %0h want 1", bus.start); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL divu_stall_issue: got %0h want 0", bus.stall); end
    step();
    bus.e_valid = 1'b0;
    bus.e_op    = 4'hf;
    for (int i = 0; i < 12; i++) begin
      bus.busy = (i < 10);
      #1;
      exp_st = (i == 0) ? 2'b01 : (i == 11) ? 2'b11 : 2'b10;
      n_cmp++; if (bus.state_o !== exp_st) begin n_bad++; $display("FAIL divu_state[%0d]: got %0h want %0h", i, bus.state_o, exp_st); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL divu_stall[%0d]: got %0h want 0", i, bus.stall); end
      step();
    end
    bus.busy = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL divu_end_state: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL divu_err: got %0h want 0", bus.proto_err); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0110;
    bus.d_is_md = 1'b1;
    #1;
    n_cmp++; if (bus.HLWr !== 1'b1) begin n_bad++; $display("FAIL mthi_hlwr: got %0h want 1", bus.HLWr); end
    n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL mthi_start: got %0h want 0", bus.start); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mthi_stall: got %0h want 0", bus.stall); end
    n_cmp++; if (bus.XALUOp !== 4'b0110) begin n_bad++; $display("FAIL mthi_xaluop: got %0h want 6", bus.XALUOp); end
    step();
    bus.e_op    = 4'b0101;
    bus.d_is_md = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL mflo_state: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.HLWr !== 1'b0) begin n_bad++; $display("FAIL mflo_hlwr: got %0h want 0", bus.HLWr); end
    n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL mflo_start: got %0h want 0", bus.start); end
    n_cmp++; if (bus.XALUOp !== 4'b0101) begin n_bad++; $display("FAIL mflo_xaluop: got %0h want 5", bus.XALUOp); end
    step();
    bus.e_valid = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL b2b_state: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.XALUOp !== 4'b1111) begin n_bad++; $display("FAIL b2b_xaluop: got %0h want f", bus.XALUOp); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %0h want 0", bus.proto_err); end
    idle_inputs();
  endtask

  task automatic test_collision();
    bus.d_is_md = 1'b1;
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0001;
    step();
    bus.e_valid = 1'b0;
    bus.busy    = 1'b1;
    step();
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0000;
    #1;
    n_cmp++; if (bus.state_o !== 2'b10) begin n_bad++; $display("FAIL coll_state: got %0h want 2", bus.state_o); end
    n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL coll_start: got %0h want 0", bus.start); end
    n_cmp++; if (bus.HLWr !== 1'b0) begin n_bad++; $display("FAIL coll_hlwr: got %0h want 0", bus.HLWr); end
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL coll_stall: got %0h want 1", bus.stall); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL coll_err_pre: got %0h want 0", bus.proto_err); end
    step();
    bus.e_valid = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b10) begin n_bad++; $display("FAIL coll_hold: got %0h want 2", bus.state_o); end
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL coll_err: got %0h want 1", bus.proto_err); end
    bus.busy = 1'b0;
    step();
    step();
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL coll_end: got %0h want 0", bus.state_o); end
    pulse_reset();
  endtask

  task automatic test_busy_overrun();
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0010;
    step();
    bus.e_valid = 1'b0;
    bus.e_op    = 4'hf;
    for (int k = 1; k <= 20; k++) begin
      bus.busy = 1'b1;
      #1;
      if (k >= 2) begin
        n_cmp++; if (bus.state_o !== 2'b10) begin n_bad++; $display("FAIL ovr_state[%0d]: got %0h want 2", k, bus.state_o); end
      end
      if (k == 12) begin
        n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL ovr_err_early: got %0h want 0", bus.proto_err); end
      end
      if (k == 14) begin
        n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL ovr_err_late: got %0h want 1", bus.proto_err); end
      end
      step();
    end
    bus.busy = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b10) begin n_bad++; $display("FAIL ovr_fall: got %0h want 2", bus.state_o); end
    step();
    n_cmp++; if (bus.state_o !== 2'b11) begin n_bad++; $display("FAIL ovr_drain: got %0h want 3", bus.state_o); end
    step();
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL ovr_idle: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %0h want 1", bus.proto_err); end
  endtask

  task automatic test_busy_missing();
    pulse_reset();
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL miss_err_clr: got %0h want 0", bus.proto_err); end
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0000;
    step();
    bus.e_valid = 1'b0;
    bus.busy    = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'b01) begin n_bad++; $display("FAIL miss_issue: got %0h want 1", bus.state_o); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL miss_err_pre: got %0h want 0", bus.proto_err); end
    step();
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL miss_idle: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL miss_err: got %0h want 1", bus.proto_err); end
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0111;
    #1;
    n_cmp++; if (bus.HLWr !== 1'b1) begin n_bad++; $display("FAIL miss_mtlo_hlwr: got %0h want 1", bus.HLWr); end
    step();
    bus.e_valid = 1'b0;
    #1;
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL miss_sticky: got %0h want 1", bus.proto_err); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.d_is_md = 1'b1;
    bus.e_valid = 1'b1;
    bus.e_op    = 4'b0010;
    step();
    bus.e_valid = 1'b0;
    bus.e_op    = 4'hf;
    bus.busy    = 1'b1;
    step();
    n_cmp++; if (bus.state_o !== 2'b10) begin n_bad++; $display("FAIL arst_pre: got %0h want 2", bus.state_o); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL arst_state: got %0h want 0", bus.state_o); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL arst_stall: got %0h want 0", bus.stall); end
    n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL arst_start: got %0h want 0", bus.start); end
    n_cmp++; if (bus.HLWr !== 1'b0) begin n_bad++; $display("FAIL arst_hlwr: got %0h want 0", bus.HLWr); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %0h want 0", bus.proto_err); end
    n_cmp++; if (bus.XALUOp !== 4'b1111) begin n_bad++; $display("FAIL arst_xaluop: got %0h want f", bus.XALUOp); end
    #1 reset = 1'b0;
    bus.busy = 1'b0;
    step();
    n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL arst_after: got %0h want 0", bus.state_o); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_back_to_back();
    test_collision();
    test_busy_overrun();
    test_busy_missing();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
